// File: rtl/cache_profile_framer.sv
// cache_profile_framer
//   Captures the cache profiler's eight 32-bit snapshot counters whenever the
//   snapshot differs from the last one framed. It then emits a 35-byte frame
//   on a valid/ready byte stream:
//     SYNC_BYTE, FRAME_ID, 32 payload bytes (words 0..7, each MSB byte first),
//     checksum = (FRAME_ID + payload bytes) mod 256.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   gates the start of new frames only
//   *_counter (x8)           profiler snapshot inputs
//   tx_data/tx_valid/tx_ready  registered byte stream to the UART transmitter
//   busy                     high while a frame is in flight
//   frames_sent              completed-frame count, wraps
module cache_profile_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] FRAME_ID  = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] icache_hit_counter,
  input  logic [31:0] icache_miss_counter,
  input  logic [31:0] icache_request_counter,
  input  logic [31:0] dcache_hit_counter,
  input  logic [31:0] dcache_miss_counter,
  input  logic [31:0] dcache_request_counter,
  input  logic [31:0] icache_line_fill_latency_counter,
  input  logic [31:0] dcache_line_fill_latency_counter,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ID, S_DATA, S_CSUM} state_t;

  state_t state, state_nxt;

  // Word 0 sits in the top 32 bits, so payload byte k is element 31-k of the
  // packed byte array. That gives MSB-first word order for free.
  logic [255:0]      cur_vec;
  logic [255:0]      last_sent, last_nxt;
  logic [31:0][7:0]  snap, snap_nxt;
  logic [4:0]        byte_idx, idx_nxt;
  logic [7:0]        csum, csum_nxt, sum;
  logic [7:0]        data_nxt;
  logic              valid_nxt;
  logic [15:0]       frames_nxt;
  logic              hs;

  assign cur_vec = {icache_hit_counter, icache_miss_counter, icache_request_counter,
                    dcache_hit_counter, dcache_miss_counter, dcache_request_counter,
                    icache_line_fill_latency_counter, dcache_line_fill_latency_counter};

  assign hs   = tx_valid && tx_ready;
  assign busy = (state != S_IDLE);

  // Next-state logic. The outputs are registered, so each transition also
  // loads the byte that will be presented in the following state.
  always_comb begin
    state_nxt  = state;
    last_nxt   = last_sent;
    snap_nxt   = snap;
    idx_nxt    = byte_idx;
    csum_nxt   = csum;
    data_nxt   = tx_data;
    valid_nxt  = tx_valid;
    frames_nxt = frames_sent;
    sum        = csum + snap[5'd31 - byte_idx];
    case (state)
      S_IDLE: begin
        if (enable && (cur_vec != last_sent)) begin
          snap_nxt  = cur_vec;
          last_nxt  = cur_vec;
          state_nxt = S_SYNC;
          valid_nxt = 1'b1;
          data_nxt  = SYNC_BYTE;
        end
      end
      S_SYNC: begin
        if (hs) begin
          state_nxt = S_ID;
          data_nxt  = FRAME_ID;
          csum_nxt  = FRAME_ID;
        end
      end
      S_ID: begin
        if (hs) begin
          state_nxt = S_DATA;
          idx_nxt   = 5'd0;
          data_nxt  = snap[31];
        end
      end
      S_DATA: begin
        if (hs) begin
          csum_nxt = sum;
          if (byte_idx == 5'd31) begin
            state_nxt = S_CSUM;
            data_nxt  = sum;
          end else begin
            idx_nxt  = byte_idx + 5'd1;
            data_nxt = snap[5'd30 - byte_idx];
          end
        end
      end
      S_CSUM: begin
        if (hs) begin
          state_nxt  = S_IDLE;
          valid_nxt  = 1'b0;
          data_nxt   = 8'h00;
          frames_nxt = frames_sent + 16'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
        data_nxt  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_sent   <= '0;
      snap        <= '0;
      byte_idx    <= '0;
      csum        <= '0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      frames_sent <= '0;
    end else begin
      state       <= state_nxt;
      last_sent   <= last_nxt;
      snap        <= snap_nxt;
      byte_idx    <= idx_nxt;
      csum        <= csum_nxt;
      tx_data     <= data_nxt;
      tx_valid    <= valid_nxt;
      frames_sent <= frames_nxt;
    end
  end

endmodule

// File: tb/tb_cache_profile_framer.sv
module tb_cache_profile_framer;

  logic        clk = 1'b0;
  logic        rst, enable, tx_ready;
  logic [31:0] w [8];
  logic [7:0]  tx_data;
  logic        tx_valid, busy;
  logic [15:0] frames_sent;

  always #5 clk = ~clk;

  cache_profile_framer dut (
    .clk(clk), .rst(rst), .enable(enable),
    .icache_hit_counter(w[0]), .icache_miss_counter(w[1]), .icache_request_counter(w[2]),
    .dcache_hit_counter(w[3]), .dcache_miss_counter(w[4]), .dcache_request_counter(w[5]),
    .icache_line_fill_latency_counter(w[6]), .dcache_line_fill_latency_counter(w[7]),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frames_sent(frames_sent)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: a frame is a list of 35 bytes; the model
  // only tracks which byte the sink is waiting for and the last framed words.
  logic [31:0] m_last [8];
  logic [7:0]  m_frame [35];
  bit          m_busy;
  int          m_pos;
  logic [15:0] m_count;
  logic [7:0]  dut_csum;

  function automatic bit differs();
    for (int i = 0; i < 8; i++) if (w[i] != m_last[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic build_frame();
    int s;
    s = 8'h01;
    m_frame[0] = 8'hA5;
    m_frame[1] = 8'h01;
    for (int k = 0; k < 32; k++) begin
      m_frame[2+k] = 8'((w[k/4] >> (8 * (3 - k % 4))) & 32'hFF);
      s += m_frame[2+k];
    end
    m_frame[34] = 8'(s % 256);
  endtask

  // Advance the model across the coming rising edge, then check the DUT at
  // the following falling edge.
  task automatic step();
    if (rst) begin
      m_busy = 0; m_pos = 0; m_count = 0;
      for (int i = 0; i < 8; i++) m_last[i] = 0;
    end else if (!m_busy) begin
      if (enable && differs()) begin
        for (int i = 0; i < 8; i++) m_last[i] = w[i];
        build_frame();
        m_busy = 1; m_pos = 0;
      end
    end else if (tx_ready) begin
      if (m_pos == 34) dut_csum = tx_data;
      m_pos++;
      if (m_pos == 35) begin
        m_busy = 0; m_pos = 0; m_count++;
      end
    end
    @(negedge clk);
    chk("tx_valid", tx_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("frames_sent", frames_sent, m_count);
    chk("tx_data", tx_data, m_busy ? m_frame[m_pos] : 8'h00);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(input string tag, input int pos, input int budget);
    int c;
    c = 0;
    while (!(m_busy && m_pos == pos) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (m_busy && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 8; i++) w[i] = v;
  endtask

  logic [15:0] base;

  initial begin
    rst = 1; enable = 1; tx_ready = 1;
    set_all(0);
    m_busy = 0; m_pos = 0; m_count = 0; dut_csum = 0;
    for (int i = 0; i < 8; i++) m_last[i] = 0;
    run(2);
    rst = 0;

    // All-zero inputs after reset match last_sent: no frame.
    run(100);
    chk("idle_zero_cnt", frames_sent, 16'd0);

    // Single nonzero word, sink always ready.
    w[2] = 32'd1;
    step();
    chk("first_sync", tx_data, 8'hA5);
    wait_idle("frame1", 60);
    chk("csum_req1", dut_csum, 8'h02);
    chk("frame1_cnt", frames_sent, 16'd1);
    run(50);

    // All ones with an alternating sink.
    set_all(32'hFFFF_FFFF);
    for (int i = 0; i < 90; i++) begin
      tx_ready = i[0];
      step();
    end
    tx_ready = 1;
    wait_idle("frame_ff", 40);
    chk("csum_ff", dut_csum, 8'hE1);
    run(5);

    // Changes mid-frame coalesce: A framed, B skipped, C framed.
    base = m_count;
    set_all(32'h1111_0000);
    wait_pos("coal_a", 2 + 10, 20);
    set_all(32'h2222_0000);
    w[5] = 32'hDEAD_BEEF;
    wait_pos("coal_b", 2 + 20, 20);
    set_all(32'h3333_0001);
    w[7] = 32'h0BAD_F00D;
    wait_idle("coal_a_end", 30);
    wait_pos("coal_c", 1, 5);
    wait_idle("coal_c_end", 50);
    run(40);
    chk("coalesce_cnt", 16'(frames_sent - base), 16'd2);

    // Reset mid-frame, then a full restart with the same nonzero inputs.
    set_all(32'h0102_0304);
    wait_pos("rst_mid", 2 + 5, 10);
    rst = 1;
    step();
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_cnt", frames_sent, 16'd0);
    rst = 0;
    step();
    chk("rst_restart", tx_data, 8'hA5);
    wait_idle("rst_frame", 50);

    // enable low blocks capture; dropping it mid-frame lets the frame finish.
    enable = 0;
    set_all(32'h5555_AAAA);
    run(40);
    chk("en_low_cnt", frames_sent, 16'd1);
    enable = 1;
    wait_pos("en_start", 3, 5);
    enable = 0;
    wait_idle("en_drop", 40);
    chk("en_drop_cnt", frames_sent, 16'd2);
    w[0] = 32'h7;
    run(20);
    enable = 1;
    step();
    chk("en_rise_sync", tx_valid, 1'b1);
    wait_idle("en_rise", 40);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      enable   = ($urandom_range(0, 19) != 0);
      rst      = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 39) == 0) begin
        int k;
        k = $urandom_range(0, 7);
        w[k] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 3));
      end
      step();
    end
    rst = 0; enable = 1; tx_ready = 1;
    wait_idle("final", 40);
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
